display_timings: RTL and testbench

- Generates raster timing for the DVI transmit path: screen coordinates, data enable, and horizontal and vertical sync.
- Sits directly upstream of the per-channel TMDS encoders.
  - o_de drives each encoder's data-enable input.
  - {o_vs, o_hs} drives the blue-channel encoder's 2-bit control input.
- Fully parameterised per video mode. Defaults are 640x480 at 60 Hz (25.2 MHz pixel clock).

---
 rtl/display_timings_pkg.sv | 70 +++++++
 rtl/display_timings.sv | 105 ++++++++++
 tb/tb_display_timings.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_timings_pkg.sv
// display_timings_pkg
// Shared types and constants for the raster timing generator.
//   region_t    : position of a coordinate within a line or frame
//   mode_e      : supported video modes
//   mode_t      : one full set of timing numbers for a mode
//   mode_params : mode_e -> mode_t lookup used to pick parameter sets
//   region_of   : classifies a coordinate into active/porch/sync
package display_timings_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_t;

  typedef enum logic [1:0] {
    MODE_640X480P60,
    MODE_800X600P60,
    MODE_1280X720P60,
    MODE_1920X1080P30
  } mode_e;

  typedef struct packed {
    int h_res;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_res;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_pol;
    bit v_pol;
  } mode_t;

  // The VGA mode uses negative syncs; the VESA/CEA modes use positive syncs.
  function automatic mode_t mode_params(input mode_e mode);
    mode_t m;
    case (mode)
      MODE_800X600P60:   m = '{h_res: 800,  h_fp: 40,  h_sync: 128, h_bp: 88,
                               v_res: 600,  v_fp: 1,   v_sync: 4,   v_bp: 23,
                               h_pol: 1'b1, v_pol: 1'b1};
      MODE_1280X720P60:  m = '{h_res: 1280, h_fp: 110, h_sync: 40,  h_bp: 220,
                               v_res: 720,  v_fp: 5,   v_sync: 5,   v_bp: 20,
                               h_pol: 1'b1, v_pol: 1'b1};
      MODE_1920X1080P30: m = '{h_res: 1920, h_fp: 88,  h_sync: 44,  h_bp: 148,
                               v_res: 1080, v_fp: 4,   v_sync: 5,   v_bp: 36,
                               h_pol: 1'b1, v_pol: 1'b1};
      default:           m = '{h_res: 640,  h_fp: 16,  h_sync: 96,  h_bp: 48,
                               v_res: 480,  v_fp: 10,  v_sync: 2,   v_bp: 33,
                               h_pol: 1'b0, v_pol: 1'b0};
    endcase
    return m;
  endfunction

  localparam mode_t DEFAULT_MODE = mode_params(MODE_640X480P60);

  // Regions are laid out in order: active, front porch, sync, back porch.
  function automatic region_t region_of(input int pos, input int res,
                                        input int fp, input int sync);
    region_t r;
    if (pos < res)                  r = REG_ACTIVE;
    else if (pos < res + fp)        r = REG_FRONT;
    else if (pos < res + fp + sync) r = REG_SYNC;
    else                            r = REG_BACK;
    return r;
  endfunction

endpackage

// File: rtl/display_timings.sv
// display_timings
// Raster timing generator feeding the DVI TMDS encoders.
// Ports:
//   i_clk   : pixel clock, all logic on the rising edge
//   i_rst   : synchronous active-high reset
//   o_sx    : horizontal position, 0..H_TOTAL-1
//   o_sy    : vertical position, 0..V_TOTAL-1
//   o_de    : high while the position is in the active picture
//   o_hs    : horizontal sync, active level H_POL
//   o_vs    : vertical sync, active level V_POL, changes only at sx==0
//   o_line  : one-cycle pulse at the start of each line
//   o_frame : one-cycle pulse at the start of each frame
module display_timings
  import display_timings_pkg::*;
#(
  parameter int H_RES  = DEFAULT_MODE.h_res,
  parameter int H_FP   = DEFAULT_MODE.h_fp,
  parameter int H_SYNC = DEFAULT_MODE.h_sync,
  parameter int H_BP   = DEFAULT_MODE.h_bp,
  parameter int V_RES  = DEFAULT_MODE.v_res,
  parameter int V_FP   = DEFAULT_MODE.v_fp,
  parameter int V_SYNC = DEFAULT_MODE.v_sync,
  parameter int V_BP   = DEFAULT_MODE.v_bp,
  parameter bit H_POL  = DEFAULT_MODE.h_pol,
  parameter bit V_POL  = DEFAULT_MODE.v_pol,
  parameter int CORDW  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_line,
  output logic             o_frame
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] SX_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] SY_LAST = CORDW'(V_TOTAL - 1);

  // Both counters must fit without wrapping early.
  if ((H_TOTAL - 1) >= (2 ** CORDW) || (V_TOTAL - 1) >= (2 ** CORDW)) begin : g_width_check
    $error("display_timings: CORDW too narrow for the selected mode");
  end

  logic [CORDW-1:0] sx_next;
  logic [CORDW-1:0] sy_next;
  region_t          h_region;
  region_t          v_region;
  logic             de_next;
  logic             hs_next;
  logic             vs_next;
  logic             line_next;
  logic             frame_next;

  // Next position. Reset parks the counters on the last pixel of the frame,
  // so the first step after release lands exactly on (0,0).
  always_comb begin
    sx_next = o_sx + 1'b1;
    sy_next = o_sy;
    if (o_sx == SX_LAST) begin
      sx_next = '0;
      sy_next = (o_sy == SY_LAST) ? '0 : o_sy + 1'b1;
    end
  end

  // Decode the position about to be shown, so that after the register
  // stage every flag lines up with the coordinates on the same cycle.
  always_comb begin
    h_region   = region_of(int'(sx_next), H_RES, H_FP, H_SYNC);
    v_region   = region_of(int'(sy_next), V_RES, V_FP, V_SYNC);
    de_next    = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    hs_next    = (h_region == REG_SYNC) ? H_POL : ~H_POL;
    vs_next    = (v_region == REG_SYNC) ? V_POL : ~V_POL;
    line_next  = (sx_next == '0);
    frame_next = (sx_next == '0) && (sy_next == '0);
  end

  // Everything is registered together; reset abandons the current position
  // and forces syncs inactive so no partial pulse survives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sx    <= SX_LAST;
      o_sy    <= SY_LAST;
      o_de    <= 1'b0;
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_sx    <= sx_next;
      o_sy    <= sy_next;
      o_de    <= de_next;
      o_hs    <= hs_next;
      o_vs    <= vs_next;
      o_line  <= line_next;
      o_frame <= frame_next;
    end
  end

endmodule

// File: tb/tb_display_timings.sv
// tb_display_timings
// Drives two instances: the default 640x480 mode (reset and line timing) and
// a tiny 8x6 mode with positive syncs (whole frames, random resets).
// Every cycle both are compared against a position model derived from the
// number of clocks since reset release.
module tb_display_timings;

  localparam int A_HR = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VR = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam bit A_HP = 1'b0, A_VP = 1'b0;
  localparam int A_HT = 800, A_VT = 525;

  localparam int B_HR = 4, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VR = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam bit B_HP = 1'b1, B_VP = 1'b1;
  localparam int B_HT = 8, B_VT = 6;

  typedef struct {
    logic [15:0] sx;
    logic [15:0] sy;
    logic        de;
    logic        hs;
    logic        vs;
    logic        line;
    logic        frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [15:0] sx_a, sy_a, sx_b, sy_b;
  logic de_a, hs_a, vs_a, line_a, frame_a;
  logic de_b, hs_b, vs_b, line_b, frame_b;

  int checks = 0;
  int errors = 0;
  int k_a = -1;
  int k_b = -1;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  display_timings dut_a (
    .i_clk(clk), .i_rst(rst_a),
    .o_sx(sx_a), .o_sy(sy_a), .o_de(de_a), .o_hs(hs_a), .o_vs(vs_a),
    .o_line(line_a), .o_frame(frame_a)
  );

  display_timings #(
    .H_RES(B_HR), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_RES(B_VR), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(B_HP), .V_POL(B_VP), .CORDW(16)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b),
    .o_sx(sx_b), .o_sy(sy_b), .o_de(de_b), .o_hs(hs_b), .o_vs(vs_b),
    .o_line(line_b), .o_frame(frame_b)
  );

  // Cycles since reset release; -1 means the reset state is showing.
  always @(posedge clk) begin
    k_a <= rst_a ? -1 : (k_a + 1) % (A_HT * A_VT);
    k_b <= rst_b ? -1 : (k_b + 1) % (B_HT * B_VT);
  end

  // Expected outputs purely from the position k cycles into a frame.
  function automatic exp_t model(input int k, input int hr, input int hf,
                                 input int hsw, input int hb, input int vr,
                                 input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, vt, x, y;
    ht = hr + hf + hsw + hb;
    vt = vr + vf + vsw + vb;
    if (k < 0) begin
      e.sx = 16'(ht - 1);
      e.sy = 16'(vt - 1);
      e.de = 1'b0;
      e.hs = ~hp;
      e.vs = ~vp;
      e.line = 1'b0;
      e.frame = 1'b0;
    end else begin
      x = k % ht;
      y = k / ht;
      e.sx = 16'(x);
      e.sy = 16'(y);
      e.de = (x < hr) && (y < vr);
      e.hs = (x >= hr + hf && x < hr + hf + hsw) ? hp : ~hp;
      e.vs = (y >= vr + vf && y < vr + vf + vsw) ? vp : ~vp;
      e.line = (x == 0);
      e.frame = (k == 0);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb);
    @(negedge clk);
    rst_a = ra;
    rst_b = rb;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (armed) begin
      ea = model(k_a, A_HR, A_HF, A_HS, A_HB, A_VR, A_VF, A_VS, A_VB, A_HP, A_VP);
      eb = model(k_b, B_HR, B_HF, B_HS, B_HB, B_VR, B_VF, B_VS, B_VB, B_HP, B_VP);
      checkOutput("a.sx", int'(sx_a), int'(ea.sx));
      checkOutput("a.sy", int'(sy_a), int'(ea.sy));
      checkOutput("a.de", int'(de_a), int'(ea.de));
      checkOutput("a.hs", int'(hs_a), int'(ea.hs));
      checkOutput("a.vs", int'(vs_a), int'(ea.vs));
      checkOutput("a.line", int'(line_a), int'(ea.line));
      checkOutput("a.frame", int'(frame_a), int'(ea.frame));
      checkOutput("b.sx", int'(sx_b), int'(eb.sx));
      checkOutput("b.sy", int'(sy_b), int'(eb.sy));
      checkOutput("b.de", int'(de_b), int'(eb.de));
      checkOutput("b.hs", int'(hs_b), int'(eb.hs));
      checkOutput("b.vs", int'(vs_b), int'(eb.vs));
      checkOutput("b.line", int'(line_b), int'(eb.line));
      checkOutput("b.frame", int'(frame_b), int'(eb.frame));
    end
  end

  initial begin
    int cnt_de, cnt_hs, cnt_line, cnt_vs, hs_first, hs_last, period, guard;

    // Reset held for five edges.
    @(posedge clk);
    armed = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.a.sx", int'(sx_a), 799);
    checkOutput("rst.a.sy", int'(sy_a), 524);
    checkOutput("rst.a.de", int'(de_a), 0);
    checkOutput("rst.a.hs", int'(hs_a), 1);
    checkOutput("rst.a.vs", int'(vs_a), 1);
    checkOutput("rst.b.hs", int'(hs_b), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First cycle after release.
    @(negedge clk);
    checkOutput("rel.a.sx", int'(sx_a), 0);
    checkOutput("rel.a.sy", int'(sy_a), 0);
    checkOutput("rel.a.de", int'(de_a), 1);
    checkOutput("rel.a.line", int'(line_a), 1);
    checkOutput("rel.a.frame", int'(frame_a), 1);
    checkOutput("rel.a.hs", int'(hs_a), 1);
    checkOutput("rel.a.vs", int'(vs_a), 1);

    // Line 0 of the default mode.
    cnt_de = 0; cnt_hs = 0; cnt_line = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      if (de_a) cnt_de++;
      if (line_a) cnt_line++;
      if (!hs_a) begin
        cnt_hs++;
        if (hs_first < 0) hs_first = int'(sx_a);
        hs_last = int'(sx_a);
      end
      @(negedge clk);
    end
    checkOutput("line0.de_cycles", cnt_de, 640);
    checkOutput("line0.hs_cycles", cnt_hs, 96);
    checkOutput("line0.hs_first", hs_first, 656);
    checkOutput("line0.hs_last", hs_last, 751);
    checkOutput("line0.line_pulses", cnt_line, 1);
    checkOutput("line1.sx", int'(sx_a), 0);
    checkOutput("line1.sy", int'(sy_a), 1);

    // Small mode: one full frame between pulses.
    guard = 0;
    while (!frame_b && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b.frame_found", int'(frame_b), 1);
    period = 0; cnt_de = 0; cnt_vs = 0;
    do begin
      if (de_b) cnt_de++;
      if (vs_b) cnt_vs++;
      @(negedge clk);
      period++;
    end while (!frame_b && period < 200);
    checkOutput("b.frame_period", period, 48);
    checkOutput("b.de_cycles", cnt_de, 12);
    checkOutput("b.vs_cycles", cnt_vs, 8);

    // Reset inside the vsync line of the small mode.
    guard = 0;
    while (!(sx_b == 16'd6 && sy_b == 16'd4) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b.reach_vsync", int'(guard < 100), 1);
    rst_b = 1'b1;
    @(negedge clk);
    checkOutput("midrst.b.vs", int'(vs_b), 0);
    checkOutput("midrst.b.hs", int'(hs_b), 0);
    checkOutput("midrst.b.sx", int'(sx_b), 7);
    checkOutput("midrst.b.sy", int'(sy_b), 5);
    rst_b = 1'b0;
    @(negedge clk);
    checkOutput("midrel.b.sx", int'(sx_b), 0);
    checkOutput("midrel.b.sy", int'(sy_b), 0);
    checkOutput("midrel.b.frame", int'(frame_b), 1);
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!frame_b && period < 200);
    checkOutput("midrel.b.period", period, 48);

    // Random reset activity on both instances.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 29) == 0));
    end
    applyStimulus(1'b0, 1'b0);
    repeat (100) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
